// File: rtl/uart_fast_read_if.sv
// uart_fast_read_if: serial receive line plus the received-byte result bus.
//   rxd          - serial line into the receiver (idle high)
//   word         - last received data byte
//   valid        - one-cycle pulse when a frame completes
//   parity_error - qualified by valid; received parity bit differs from ^word
//   frame_error  - qualified by valid; stop-bit sample was 0
//   busy         - receiver is inside a frame
// slave modport is the receiver's view; master modport is the line driver / consumer.
interface uart_fast_read_if;
    logic       rxd;
    logic [7:0] word;
    logic       valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    modport master (
        output rxd,
        input  word, valid, parity_error, frame_error, busy
    );

    modport slave (
        input  rxd,
        output word, valid, parity_error, frame_error, busy
    );
endinterface

// File: rtl/uart_fast_read.sv
// uart_fast_read: UART receiver for 11-bit frames (start 0, 8 data bits LSB
// first, even parity, stop 1). Samples each bit once at HALF + k*N cycles after
// the first low sample seen in IDLE; no oversampling or synchroniser.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active high
//   rx    - uart_fast_read_if.slave: rxd in; word/valid/parity_error/
//           frame_error/busy out
module uart_fast_read #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_fast_read_if.slave   rx
);

    localparam int unsigned HALF      = (CLKS_PER_BIT - 1) / 2;
    localparam logic [7:0]  LAST      = 8'(CLKS_PER_BIT - 1);
    // START is entered one cycle after t0, so its sample lands at count HALF-1.
    localparam logic [7:0]  HALF_LAST = 8'((HALF == 0) ? 0 : HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sreg, sreg_n;
    logic       par, par_n;
    logic [7:0] word_r, word_n;
    logic       valid_r, valid_n;
    logic       pe_r, pe_n;
    logic       fe_r, fe_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sreg    <= '0;
            par     <= 1'b0;
            word_r  <= '0;
            valid_r <= 1'b0;
            pe_r    <= 1'b0;
            fe_r    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sreg    <= sreg_n;
            par     <= par_n;
            word_r  <= word_n;
            valid_r <= valid_n;
            pe_r    <= pe_n;
            fe_r    <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sreg_n  = sreg;
        par_n   = par;
        word_n  = word_r;
        valid_n = 1'b0;
        pe_n    = pe_r;
        fe_n    = fe_r;

        case (state)
            IDLE: begin
                if (!rx.rxd) begin
                    cnt_n = '0;
                    idx_n = '0;
                    // With HALF = 0 this low sample is itself the start sample.
                    if (HALF == 0) state_n = DATA;
                    else           state_n = START;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    idx_n = '0;
                    if (!rx.rxd) state_n = DATA;
                    else         state_n = IDLE;   // glitch: false start
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            DATA: begin
                if (cnt == LAST) begin
                    cnt_n  = '0;
                    // Shift in from the MSB side so bit 0 ends up at sreg[0].
                    sreg_n = {rx.rxd, sreg[7:1]};
                    idx_n  = idx + 3'd1;
                    if (idx == 3'd7) state_n = PARITY;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            PARITY: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    par_n   = rx.rxd;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    word_n  = sreg;
                    valid_n = 1'b1;
                    pe_n    = par ^ (^sreg);
                    fe_n    = !rx.rxd;
                    // A low stop means a break may be in progress; wait for idle.
                    state_n = rx.rxd ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            WAIT_HIGH: begin
                if (rx.rxd) state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    assign rx.word         = word_r;
    assign rx.valid        = valid_r;
    assign rx.parity_error = pe_r;
    assign rx.frame_error  = fe_r;
    assign rx.busy         = (state == START) || (state == DATA) ||
                             (state == PARITY) || (state == STOP);

endmodule

// File: tb/tb_uart_fast_read.sv
// tb_uart_fast_read: directed frames into an N=1 and an N=4 receiver.
// Expected byte/flags/arrival cycle are queued when a frame is sent; a
// negedge monitor pops and compares on every valid pulse.
module tb_uart_fast_read;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_fast_read_if if1 ();
    uart_fast_read_if if4 ();

    uart_fast_read #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .reset(reset), .rx(if1));
    uart_fast_read #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .reset(reset), .rx(if4));

    typedef struct {
        logic [7:0] w;
        logic       pe;
        logic       fe;
        int         cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] w,
                       input logic pe, input logic fe);
        chk({tag, " word"}, 32'(w), 32'(e.w));
        chk({tag, " parity_error"}, 32'(pe), 32'(e.pe));
        chk({tag, " frame_error"}, 32'(fe), 32'(e.fe));
        chk({tag, " valid cycle"}, 32'(cyc), 32'(e.cyc));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (if1.valid !== 1'b0) begin
                if (q1.size() == 0) chk("n1 unexpected valid", 32'(if1.valid), 32'd0);
                else cmp("n1", q1.pop_front(), if1.word, if1.parity_error, if1.frame_error);
            end
            if (if4.valid !== 1'b0) begin
                if (q4.size() == 0) chk("n4 unexpected valid", 32'(if4.valid), 32'd0);
                else cmp("n4", q4.pop_front(), if4.word, if4.parity_error, if4.frame_error);
            end
        end
    end

    task automatic drive(input bit sel, input logic b);
        if (sel) if4.rxd = b;
        else     if1.rxd = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel, input int n);
        for (int i = 0; i < n; i++) drive(sel, 1'b1);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic p,
                        input logic stp, input bit chk_busy);
        int n;
        int half;
        logic [10:0] f;
        exp_t e;
        n    = sel ? 4 : 1;
        half = sel ? 1 : 0;
        f    = {stp, p, d, 1'b0};
        e.w   = d;
        e.pe  = p ^ (^d);
        e.fe  = !stp;
        e.cyc = cyc + half + 10 * n + 1;
        if (sel) q4.push_back(e);
        else     q1.push_back(e);
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < n; j++) drive(sel, f[i]);
            if (chk_busy) chk("n1 busy in frame", 32'(if1.busy), (i < 10) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [10:0] fc3;
        if1.rxd = 1'b1;
        if4.rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("n1 reset word", 32'(if1.word), 32'h00);
        chk("n1 reset valid", 32'(if1.valid), 32'd0);
        chk("n1 reset busy", 32'(if1.busy), 32'd0);
        chk("n1 reset parity_error", 32'(if1.parity_error), 32'd0);
        chk("n1 reset frame_error", 32'(if1.frame_error), 32'd0);
        chk("n4 reset busy", 32'(if4.busy), 32'd0);
        reset = 1'b0;
        idle(0, 5);
        chk("n1 idle valid", 32'(if1.valid), 32'd0);
        chk("n1 idle busy", 32'(if1.busy), 32'd0);
        chk("n1 idle word", 32'(if1.word), 32'h00);

        // A5 with busy tracking
        send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        idle(0, 2);

        // back-to-back 01 then FF
        send(0, 8'h01, 1'b1, 1'b1, 1'b0);
        send(0, 8'hFF, 1'b0, 1'b1, 1'b0);
        idle(0, 3);
        chk("n1 word holds", 32'(if1.word), 32'hFF);

        // parity error
        send(0, 8'h3C, 1'b1, 1'b1, 1'b0);
        idle(0, 2);

        // framing error then held break
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(0, 1'b0);
        chk("n1 busy during break", 32'(if1.busy), 32'd0);
        idle(0, 3);
        send(0, 8'h81, 1'b0, 1'b1, 1'b0);
        idle(0, 2);

        // N=4 glitch rejection then a full frame
        drive(1, 1'b0);
        chk("n4 busy after low sample", 32'(if4.busy), 32'd1);
        drive(1, 1'b1);
        chk("n4 busy after glitch", 32'(if4.busy), 32'd0);
        idle(1, 6);
        send(1, 8'h5A, 1'b0, 1'b1, 1'b0);
        idle(1, 4);

        // reset aborts a C3 frame mid-data
        fc3 = {1'b1, 1'b0, 8'hC3, 1'b0};
        for (int i = 0; i < 6; i++) drive(0, fc3[i]);
        chk("n1 busy mid-frame", 32'(if1.busy), 32'd1);
        reset = 1'b1;
        drive(0, 1'b1);
        chk("n1 abort busy", 32'(if1.busy), 32'd0);
        chk("n1 abort valid", 32'(if1.valid), 32'd0);
        chk("n1 abort word", 32'(if1.word), 32'h00);
        reset = 1'b0;
        idle(0, 15);
        send(0, 8'h0F, 1'b0, 1'b1, 1'b0);

        idle(0, 20);
        chk("n1 frames outstanding", 32'(q1.size()), 32'd0);
        chk("n4 frames outstanding", 32'(q4.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_fast_read.md
# uart_fast_read

Receive-side counterpart of the fast UART transmitter in the receiver path. Deserialises one 11-bit frame from the single-bit `rxd` line: start bit 0, 8 data bits LSB first, even parity bit (`^word`), stop bit 1. It checks parity and framing, then presents the byte with a one-cycle `valid` pulse. At the default `CLKS_PER_BIT = 1` it accepts the transmitter's one-bit-per-clock stream directly, with no oversampling.

## Interface
- `CLKS_PER_BIT`, 1, clock cycles per line bit; legal range 1..255.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rxd`  in  1  serial line, idle high, driven synchronously in the `clk` domain; no synchroniser inside.
- `word`  out  8  last received data byte; holds until the next frame completes.
- `valid`  out  1  one-cycle pulse when a frame completes, good or bad.
- `parity_error`  out  1  qualified by `valid`; 1 when the received parity bit is not `^word`.
- `frame_error`  out  1  qualified by `valid`; 1 when the stop-bit sample is 0.
- `busy`  out  1  high from start detection until the frame's `valid` cycle.

## Operation
- `HALF = (CLKS_PER_BIT-1)/2`, integer division; `HALF = 0` for N=1.
- t0 is the first cycle `rxd` is sampled 0 while in IDLE.
- Sample points are at t0 + HALF + k·N:
  - k=0: start bit
  - k=1..8: data bits 0..7
  - k=9: parity bit
  - k=10: stop bit
- State machine, with a bit-period counter and a bit index:
  - IDLE: `rxd`=0 → START. For HALF=0 the start sample is taken in this same cycle and the FSM goes straight to DATA.
  - START: at the start sample, `rxd`=0 → DATA. `rxd`=1 → false start: return to IDLE, no `valid`, no state change on outputs.
  - DATA: shift sample k into `word` bit k-1 (shift register loads MSB side, ends LSB-aligned) → PARITY after 8 samples.
  - PARITY: capture the parity bit → STOP.
  - STOP: at the stop sample, register `valid`=1 for the next cycle, with `parity_error` = (parity bit ≠ ^data) and `frame_error` = !stop.
    - stop=1 → IDLE.
    - stop=0 → WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd`=1, then IDLE. This prevents a held-low break from being read as back-to-back zero frames.
- `word` updates only on the `valid` cycle, from the shift register; the partially shifted value is never visible.
- `parity_error` and `frame_error` hold their last values between pulses; consumers use them only with `valid`.
- `busy` is 1 in START/DATA/PARITY/STOP, and 0 in IDLE and WAIT_HIGH.

## Timing
- Reset values: `word`=8'h00, `valid`=0, `parity_error`=0, `frame_error`=0, `busy`=0, FSM=IDLE, counters 0.
- Latency: `valid` is high at cycle t0 + HALF + 10·N + 1. For N=1 that is t0+11.
- Back-to-back frames:
  - After a good stop sample the FSM is in IDLE on the very next cycle.
  - A start bit on that cycle, which is also the `valid` cycle, is accepted with no lost bit.
  - The transmitter's minimum 11-cycle frame spacing is therefore always received.
- `reset` mid-frame aborts the frame: no `valid`, all outputs at reset values on the next cycle. If `rxd` is low after reset is released, it is treated as a new start bit.
- A `rxd` glitch is only filtered when N>1, via the start re-check at HALF. At N=1 any low sample in IDLE is a start.
- No backpressure: `valid` is not held. A consumer that misses the pulse loses the byte.

## Test plan
- N=1, reset then `rxd` idle 1 for 5 cycles → `valid`=0, `busy`=0, `word`=8'h00.
- N=1, frame for 8'hA5: line 0, 1,0,1,0,0,1,0,1, 0, 1 starting at t0 → at t0+11, `valid`=1, `word`=8'hA5, both errors 0; `busy` high t0..t0+10.
- N=1, two frames 8'h01 (parity 1) then 8'hFF (parity 0) with zero idle between → two `valid` pulses 11 cycles apart, words 01 then FF, no errors.
- N=1, frame 8'h3C with parity bit flipped to 1 → `valid` with `word`=8'h3C, `parity_error`=1, `frame_error`=0. Frame 8'h3C with stop bit 0 and line then held low 20 cycles → `frame_error`=1, no further `valid` until `rxd` returns high and a new frame arrives.
- N=4: a 1-cycle low pulse in idle → no `valid`, FSM back in IDLE. A full 8'h5A frame at 4 cycles per bit → `valid` at t0+1+40+1 = t0+42, `word`=8'h5A, no errors.
- N=1, assert `reset` at bit 5 of an 8'hC3 frame → `busy`=0, `valid` never pulses for it. The next clean 8'h0F frame is received correctly.
